unsigned_approx_mult_pipe: RTL and testbench

UNSIGNED_APPROX_MULT_PIPE -- requirements
Module: unsigned_approx_mult_pipe

---
 rtl/unsigned_approx_mult_pipe_if.sv | 26 ++
 rtl/unsigned_approx_mult_pipe.sv | 94 +++++++++
 tb/tb_unsigned_approx_mult_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_approx_mult_pipe_if.sv
// Operand/result bus of the approximate multiplier pipeline.
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1; valid never waits on ready.
interface unsigned_approx_mult_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 approx_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   z;
   logic [CNT_W-1:0]     approx_cnt;

   modport master (
      output in_valid, x, y, approx_en, out_ready,
      input  in_ready, out_valid, z, approx_cnt
   );

   modport slave (
      input  in_valid, x, y, approx_en, out_ready,
      output in_ready, out_valid, z, approx_cnt
   );
endinterface

// File: rtl/unsigned_approx_mult_pipe.sv
// Two-stage unsigned multiplier with optional truncation of the low L rows of x,
// a small carry compensation term, and a saturating count of approximate results.
module unsigned_approx_mult_pipe #(
   parameter int WIDTH = 8,
   parameter int L     = 2,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   unsigned_approx_mult_pipe_if.slave bus
);
   localparam int PW = 2 * WIDTH;

   logic             s1_full;
   logic             s1_ae;
   logic [PW-1:0]    s1_prod;
   logic [1:0]       s1_c;
   logic             s2_full;
   logic             s2_ae;
   logic [PW-1:0]    s2_z;
   logic [CNT_W-1:0] cnt;

   logic             s2_adv;
   logic             out_fire;
   logic [PW-1:0]    p_upper;
   logic [PW-1:0]    p_exact;
   logic [1:0]       c_next;
   logic [PW-1:0]    z_next;

   // S2 can take new data when empty or when its current result leaves this cycle.
   assign s2_adv       = !s2_full || bus.out_ready;
   assign bus.in_ready = !s1_full || s2_adv;
   assign out_fire     = s2_full && bus.out_ready;

   assign bus.out_valid  = s2_full;
   assign bus.z          = s2_z;
   assign bus.approx_cnt = cnt;

   always_comb begin
      p_upper = PW'(bus.x >> L) * PW'(bus.y);
      p_exact = PW'(bus.x) * PW'(bus.y);
      c_next  = 2'd0;
      if (L == 1) begin
         c_next = {1'b0, bus.x[0] & bus.y[WIDTH-1]};
      end else if (L == 2) begin
         c_next = {1'b0, (bus.x[0] & bus.y[WIDTH-1]) | (bus.x[1] & bus.y[WIDTH-2])}
                + {1'b0, bus.x[1] & bus.y[WIDTH-1]};
      end
   end

   // In exact mode s1_prod already carries the full product and needs no rework.
   always_comb begin
      z_next = s1_prod;
      if (s1_ae) begin
         z_next = (s1_prod << L) + (PW'(s1_c) << WIDTH);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_full <= 1'b0;
         s1_ae   <= 1'b0;
         s1_prod <= '0;
         s1_c    <= 2'd0;
      end else if (bus.in_ready) begin
         s1_full <= bus.in_valid;
         if (bus.in_valid) begin
            s1_ae   <= bus.approx_en;
            s1_prod <= bus.approx_en ? p_upper : p_exact;
            s1_c    <= bus.approx_en ? c_next : 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_full <= 1'b0;
         s2_ae   <= 1'b0;
         s2_z    <= '0;
         cnt     <= '0;
      end else begin
         if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
               s2_z  <= z_next;
               s2_ae <= s1_ae;
            end
         end
         if (out_fire && s2_ae && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Bench for unsigned_approx_mult_pipe (WIDTH=8, L=2, CNT_W=2): directed cases plus
// random traffic with random back-pressure against an arithmetic reference model.
module tb_unsigned_approx_mult_pipe;
   localparam int WIDTH   = 8;
   localparam int L       = 2;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   unsigned_approx_mult_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   unsigned_approx_mult_pipe #(.WIDTH(WIDTH), .L(L), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int                 n_checks = 0;
   int                 n_pass   = 0;
   logic [2*WIDTH-1:0] exp_q[$];
   bit                 ae_q[$];
   int                 model_cnt = 0;
   bit                 stall_prev = 1'b0;
   logic [2*WIDTH-1:0] held_z;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reference: exact product, or y*floor(x/4)*4 plus compensation*256, from the bit rules.
   function automatic logic [2*WIDTH-1:0] ref_z(input int a, input int b, input bit ae);
      int p, c, x0, x1, y6, y7;
      if (!ae) return (2*WIDTH)'(a * b);
      x0 = a % 2;
      x1 = (a / 2) % 2;
      y7 = (b / 128) % 2;
      y6 = (b / 64) % 2;
      p  = b * (a / 4);
      c  = (((x0 == 1) && (y7 == 1)) || ((x1 == 1) && (y6 == 1))) ? 1 : 0;
      c  = c + (((x1 == 1) && (y7 == 1)) ? 1 : 0);
      return (2*WIDTH)'((p * 4 + c * 256) % 65536);
   endfunction

   // Monitor: samples on the falling edge, so it sees what the next rising edge will transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            check("z_hold", bus.z, held_z);
            check("valid_hold", bus.out_valid, 1);
         end
         check("approx_cnt", bus.approx_cnt, model_cnt);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", bus.out_valid, 0);
            end else begin
               check("z_order", bus.z, exp_q.pop_front());
               if (ae_q.pop_front() && (model_cnt < CNT_MAX)) model_cnt++;
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_z     = bus.z;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_z(int'(bus.x), int'(bus.y), bus.approx_en));
            ae_q.push_back(bus.approx_en);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit ae);
      int guard = 0;
      bus.x         = a;
      bus.y         = b;
      bus.approx_en = ae;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("send_accept", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("drain_empty", exp_q.size(), 0);
      tick();
   endtask

   task automatic do_reset();
      tick();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      ae_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int next_val;
      int sent;
      bit acc;
      logic [WIDTH-1:0] ra, rb;

      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.approx_en = 1'b0;
      bus.out_ready = 1'b1;

      // Reset takes effect without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_z", bus.z, 0);
      check("rst_cnt", bus.approx_cnt, 0);
      check("rst_in_ready", bus.in_ready, 1);

      // First acceptance on the first edge after release; result visible after the next edge.
      tick();
      tick();
      rst_n         = 1'b1;
      bus.x         = 8'd255;
      bus.y         = 8'd255;
      bus.approx_en = 1'b1;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check("first_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_not_yet", bus.out_valid, 0);
      tick();
      @(negedge clk);
      check("lat_valid", bus.out_valid, 1);
      check("z_255x255_approx", bus.z, 64772);
      tick();
      @(negedge clk);
      check("cnt_after_first", bus.approx_cnt, 1);
      check("valid_after_take", bus.out_valid, 0);
      tick();

      send(8'd255, 8'd255, 1'b0);
      drain();
      check("z_255x255_exact", bus.z, 65025);
      check("cnt_exact_unchanged", bus.approx_cnt, 1);

      send(8'd3, 8'd200, 1'b1);
      send(8'd4, 8'd10, 1'b1);
      drain();
      check("z_4x10_approx", bus.z, 40);

      // Counter saturation at CNT_W=2.
      do_reset();
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 1'b1);
         drain();
         check("cnt_sat_seq", bus.approx_cnt, (i < CNT_MAX) ? i : CNT_MAX);
      end

      // Back-pressure: 5 cycles with out_ready=0 while streaming 1..5 times 1.
      bus.out_ready = 1'b0;
      next_val = 1;
      for (int c = 0; c < 5; c++) begin
         bus.x         = WIDTH'(next_val);
         bus.y         = 8'd1;
         bus.approx_en = 1'b0;
         bus.in_valid  = 1'b1;
         @(negedge clk);
         if (bus.in_ready) next_val++;
         tick();
      end
      @(negedge clk);
      check("stall_accepted", next_val - 1, 2);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_z", bus.z, 1);
      tick();
      bus.out_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         bus.x        = WIDTH'(next_val);
         bus.in_valid = (next_val <= 5);
         @(negedge clk);
         check("release_valid", bus.out_valid, 1);
         check("release_z", bus.z, r + 1);
         acc = bus.in_valid && bus.in_ready;
         if (acc) next_val++;
         tick();
      end
      bus.in_valid = 1'b0;
      drain();

      // Random traffic with random back-pressure.
      sent = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!bus.in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 7))
               0:       ra = 8'd255;
               1:       ra = 8'd0;
               default: ra = WIDTH'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 7))
               0:       rb = 8'd255;
               1:       rb = 8'd0;
               default: rb = WIDTH'($urandom_range(0, 255));
            endcase
            bus.x         = ra;
            bus.y         = rb;
            bus.approx_en = $urandom_range(0, 1) == 1;
            bus.in_valid  = 1'b1;
            sent++;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      for (int g = 0; g < 20 && bus.in_valid; g++) begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         if (acc) bus.in_valid = 1'b0;
      end
      check("random_in_done", bus.in_valid, 0);
      drain();

      // Reset with two transactions in flight.
      bus.out_ready = 1'b0;
      send(8'd10, 8'd20, 1'b1);
      send(8'd30, 8'd40, 1'b1);
      @(negedge clk);
      check("inflight_valid", bus.out_valid, 1);
      do_reset();
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_cnt", bus.approx_cnt, 0);
      tick();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("no_stale_out", bus.out_valid, 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
